fetch_mt: RTL and testbench
===========================

Name: fetch_mt

Overview:
Parametrised multi-thread fetch/load-store unit for the CPU core, successor to the single-width, two-thread FETCH. It serves one request per access from the pipeline. Addresses inside the register window hit a per-thread register file in one cycle. All other addresses become a single-beat bus master transaction on the same clock, with error and timeout reporting that FETCH lacks.

Parameters:
DATA_W, 32, data width of requests, register file and bus
ADDR_W, 32, address width
NUM_THREADS, 4, hardware threads; TID_W = max(1, clog2(NUM_THREADS))
NUM_REGS, 16, registers per thread; must be a power of two, at most 2^ADDR_W
REG_BASE, 32'hFFFF_FFF0, first address of the register window; must be aligned to NUM_REGS
TIMEOUT, 255, bus cycles to wait for bus_ack/bus_err; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  access request (f_enable)
req_write  in  1  1 = write, 0 = read
req_thread  in  TID_W  issuing thread
req_addr  in  ADDR_W  access address
req_wdata  in  DATA_W  write data
rsp_ack  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_ack; bus error or timeout
rsp_rdata  out  DATA_W  read data, valid with rsp_ack on reads
bus_cyc  out  1  bus transaction active
bus_we  out  1  bus write strobe
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data
bus_ack  in  1  bus completion
bus_err  in  1  bus error completion

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; timeout counter 0; every register of every thread cleared to 0. Reset during BUS drops bus_cyc immediately; no rsp_ack is produced for the aborted request.
- Register window: hit when REG_BASE <= req_addr < REG_BASE+NUM_REGS; index = req_addr[clog2(NUM_REGS)-1:0].
- FSM states: IDLE, BUS.
- IDLE with req_valid and a window hit:
  - Write: stores req_wdata at regs[req_thread][index] on the edge.
  - Read: registers regs[req_thread][index] into rsp_rdata.
  - rsp_ack=1 and rsp_err=0 the following cycle. Latency is 1.
  - State stays IDLE, so a continuously held req_valid with new addr/thread completes one access per cycle (fast-forward).
- IDLE with req_valid and a window miss:
  - Latch addr, wdata and write into the bus_* outputs; bus_cyc=1; go to BUS.
  - rsp_ack=0 on this edge.
- BUS:
  - bus_* outputs held stable; timeout counter increments each cycle.
  - On bus_ack: rsp_ack=1; rsp_rdata=bus_rdata if read; bus_cyc, bus_we, bus_addr, bus_wdata all return to 0; go to IDLE.
  - bus_err, alone or with bus_ack: same as bus_ack but rsp_err=1 and rsp_rdata=0.
  - Timeout when the counter reaches TIMEOUT (TIMEOUT != 0): same as bus_err.
  - req_* is ignored while in BUS. The requester must hold req_* stable until it sees rsp_ack.
- rsp_ack is high for exactly one cycle per access. rsp_rdata holds its value until the next completion.
- A request presented in the cycle rsp_ack is high is accepted normally (IDLE). Memory accesses therefore have a minimum latency of 2 cycles.
- While bus_cyc=0, bus outputs are driven to 0, never z.
- Thread isolation: an access never reads or modifies another thread's registers. Out-of-range req_thread (when NUM_THREADS is not a power of two) acts as a register-window miss.

Decomposition:
- Package fetch_mt_pkg: state enum (IDLE, BUS); default REG_BASE; helper function reg_hit(addr).
- Sub-module fetch_regfile (NUM_THREADS x NUM_REGS x DATA_W, one synchronous R/W port, async clear). The FSM, bus master and timeout counter stay in fetch_mt.

Test Plan:
- Register write/read: write t0 addr FFFF_FFF0 = 1111_1111, then t1 FFFF_FFF1 = 2222_2222 with req_valid held -> rsp_ack high each following cycle. Read t0 FFFF_FFF0 -> 1111_1111. Read t1 FFFF_FFF1 -> 2222_2222. Read t1 FFFF_FFF0 -> 0 (isolation).
- Memory write: write addr 0000_0001 data 0000_0011.
  - Next cycle: bus_cyc=1, bus_we=1, bus_addr=0000_0001, bus_wdata=0000_0011, rsp_ack=0.
  - Hold bus_ack=0 for 3 cycles, then pulse 1 -> rsp_ack=1 the next cycle and bus_addr=0.
- Memory read: read 0000_0100; bus returns bus_rdata=DEAD_BEEF with bus_ack after 2 cycles -> rsp_rdata=DEAD_BEEF, rsp_err=0.
- Bus error: bus_err=1 in the first BUS cycle -> rsp_ack=1, rsp_err=1, rsp_rdata=0.
- Timeout with TIMEOUT=4 and the bus silent -> rsp_ack=1 and rsp_err=1 exactly 5 cycles after acceptance. A subsequent register access completes normally.
- Reset mid-BUS: rst_n=0 during BUS -> bus_cyc=0 immediately and no rsp_ack. After release, register reads return 0.

Source files
------------

// File: rtl/fetch_mt_pkg.sv
// Shared types and helpers for the multi-thread fetch/load-store unit.
package fetch_mt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_REG_BASE = 32'hFFFF_FFF0;

  // Window test done in 64 bits so base + size cannot wrap at the top of the
  // address space (the default window ends exactly at 2^32).
  function automatic logic reg_hit(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] num_regs);
    return (addr >= base) && (addr < base + num_regs);
  endfunction

endpackage

// File: rtl/fetch_regfile.sv
// Per-thread register file: NUM_THREADS x NUM_REGS words, one synchronous
// write port, a combinational read port (registered by the caller), and a
// full asynchronous clear.
module fetch_regfile #(
  parameter int DATA_W      = 32,
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = 2,
  parameter int NUM_REGS    = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [TID_W-1:0]  thread,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_THREADS][NUM_REGS];

  // Read data for the addressed thread/register; the top registers it.
  assign rdata = regs[thread][idx];

  // Storage update: async clear of every word, otherwise a single write.
  // NOTE: the array is reset, so it maps to flops rather than a RAM macro;
  // that is intended, every register must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          // NOTE: sequential state always uses <=, so every reader sees the
          // pre-edge value regardless of process ordering.
          regs[t][r] <= '0;
        end
      end
    end else if (we) begin
      regs[thread][idx] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_mt.sv
// Multi-thread fetch/load-store unit: register-window accesses complete in
// one cycle from a per-thread register file; everything else becomes a
// single-beat bus transaction with error and timeout reporting.
module fetch_mt
  import fetch_mt_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_THREADS = 4,
  parameter int                TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] REG_BASE    = ADDR_W'(DEFAULT_REG_BASE),
  parameter int                TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [TID_W-1:0]  req_thread,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_ack,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_cyc,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              thread_ok, hit, timed_out;
  logic              accept_hit, accept_miss, bus_done, bus_fail;
  logic [DATA_W-1:0] reg_rdata;

  // A thread id beyond NUM_THREADS can only exist when the count is not a
  // power of two; such ids are treated as window misses.
  if (NUM_THREADS == (1 << TID_W)) begin : g_full_tid
    assign thread_ok = 1'b1;
  end else begin : g_part_tid
    assign thread_ok = (32'(req_thread) < 32'(NUM_THREADS));
  end

  assign hit       = reg_hit(64'(req_addr), 64'(REG_BASE), 64'(NUM_REGS)) && thread_ok;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  fetch_regfile #(
    .DATA_W      (DATA_W),
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept_hit && req_write),
    .thread (req_thread),
    .idx    (req_addr[IDX_W-1:0]),
    .wdata  (req_wdata),
    .rdata  (reg_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle decisions: accept a request or finish the bus beat.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d     = state_q;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    bus_done    = 1'b0;
    bus_fail    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            accept_hit = 1'b1;
          end else begin
            accept_miss = 1'b1;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        bus_fail = bus_err || timed_out;
        bus_done = bus_ack || bus_fail;
        if (bus_done) state_d = IDLE;
      end
    endcase
  end

  // Timeout counter: counts cycles spent in BUS, cleared whenever idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt_q <= '0;
    else if ((state_q == BUS) && !bus_done)  cnt_q <= cnt_q + 1'b1;
    else                                     cnt_q <= '0;
  end

  // Response and bus-master outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ack   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      bus_cyc   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      rsp_ack <= 1'b0;
      rsp_err <= 1'b0;
      if (accept_hit) begin
        rsp_ack <= 1'b1;
        if (!req_write) rsp_rdata <= reg_rdata;
      end
      if (accept_miss) begin
        bus_cyc   <= 1'b1;
        bus_we    <= req_write;
        bus_addr  <= req_addr;
        bus_wdata <= req_wdata;
      end
      if (bus_done) begin
        rsp_ack <= 1'b1;
        rsp_err <= bus_fail;
        if (bus_fail)     rsp_rdata <= '0;
        else if (!bus_we) rsp_rdata <= bus_rdata;
        bus_cyc   <= 1'b0;
        bus_we    <= 1'b0;
        bus_addr  <= '0;
        bus_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_mt.sv
// Self-checking bench for fetch_mt: a transaction-level model predicts every
// output each cycle, and directed checks pin the key values by hand.
module tb_fetch_mt;

  localparam int          TMO  = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]  req_thread = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_ack, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_cyc, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;

  int tests = 0;
  int fails = 0;

  fetch_mt #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_thread (req_thread),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_ack    (rsp_ack),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .bus_cyc    (bus_cyc),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [4][16];
  bit          m_busy;
  int          m_wait;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic        exp_ack, exp_err;
  logic [31:0] exp_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[t, r]) m_regs[t][r] = '0;
      m_busy = 0; m_wait = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      exp_ack = 0; exp_err = 0; exp_rdata = '0;
    end else begin
      exp_ack = 0;
      exp_err = 0;
      if (!m_busy) begin
        if (req_valid) begin
          if (req_addr >= BASE) begin
            // Window is the top 16 addresses; offset picks the register.
            logic [31:0] off;
            off = req_addr - BASE;
            if (req_write) m_regs[req_thread][off[3:0]] = req_wdata;
            else           exp_rdata = m_regs[req_thread][off[3:0]];
            exp_ack = 1;
          end else begin
            m_busy = 1; m_wait = 0;
            m_we = req_write; m_addr = req_addr; m_wdata = req_wdata;
          end
        end
      end else begin
        m_wait++;  // edges seen since acceptance
        if (bus_err || m_wait > TMO) begin
          exp_ack = 1; exp_err = 1; exp_rdata = '0; m_busy = 0;
        end else if (bus_ack) begin
          exp_ack = 1;
          if (!m_we) exp_rdata = bus_rdata;
          m_busy = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("ack",       32'(rsp_ack),  32'(exp_ack));
    check("err",       32'(rsp_err),  32'(exp_err));
    check("rdata",     rsp_rdata,     exp_rdata);
    check("bus_cyc",   32'(bus_cyc),  32'(m_busy));
    check("bus_we",    32'(bus_we),   m_busy ? 32'(m_we) : 32'd0);
    check("bus_addr",  bus_addr,      m_busy ? m_addr : 32'd0);
    check("bus_wdata", bus_wdata,     m_busy ? m_wdata : 32'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_thread = t; req_addr = a; req_wdata = d;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst ack",     32'(rsp_ack), 32'd0);
    check("rst cyc",     32'(bus_cyc), 32'd0);
    check("rst rdata",   rsp_rdata,    32'd0);
    check("rst addr",    bus_addr,     32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Register writes back-to-back with req_valid held.
    drive(1, 1, 2'd0, 32'hFFFF_FFF0, 32'h1111_1111);
    step(); check("wr t0 ack", 32'(rsp_ack), 32'd1);
    drive(1, 1, 2'd1, 32'hFFFF_FFF1, 32'h2222_2222);
    step(); check("wr t1 ack", 32'(rsp_ack), 32'd1);
    drive(1, 0, 2'd0, 32'hFFFF_FFF0, 32'h0);
    step(); check("rd t0 ack", 32'(rsp_ack), 32'd1);
            check("rd t0",     rsp_rdata,    32'h1111_1111);
    drive(1, 0, 2'd1, 32'hFFFF_FFF1, 32'h0);
    step(); check("rd t1",     rsp_rdata,    32'h2222_2222);
    drive(1, 0, 2'd1, 32'hFFFF_FFF0, 32'h0);
    step(); check("rd t1 iso", rsp_rdata,    32'h0);
    drive(0, 0, 2'd0, 32'h0, 32'h0);
    step(); check("idle ack",  32'(rsp_ack), 32'd0);

    // Memory write, bus silent for 3 cycles then acks.
    drive(1, 1, 2'd0, 32'h0000_0001, 32'h0000_0011);
    step();
    check("mw cyc",   32'(bus_cyc), 32'd1);
    check("mw we",    32'(bus_we),  32'd1);
    check("mw addr",  bus_addr,     32'h0000_0001);
    check("mw wdata", bus_wdata,    32'h0000_0011);
    check("mw ack0",  32'(rsp_ack), 32'd0);
    repeat (3) begin
      step(); check("mw wait", 32'(rsp_ack), 32'd0);
    end
    bus_ack = 1'b1;
    step();
    check("mw ack",   32'(rsp_ack), 32'd1);
    check("mw addr0", bus_addr,     32'd0);
    bus_ack = 1'b0;
    drive(0, 0, 2'd0, 32'h0, 32'h0);

    // Memory read, bus answers in its second cycle.
    drive(1, 0, 2'd2, 32'h0000_0100, 32'h0);
    step(); check("mr we", 32'(bus_we), 32'd0);
    step(); check("mr wait", 32'(rsp_ack), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    check("mr ack",   32'(rsp_ack), 32'd1);
    check("mr err",   32'(rsp_err), 32'd0);
    check("mr rdata", rsp_rdata,    32'hDEAD_BEEF);
    bus_ack = 1'b0;
    drive(0, 0, 2'd0, 32'h0, 32'h0);

    // Bus error in the first BUS cycle (bus_rdata still non-zero).
    drive(1, 0, 2'd3, 32'h0000_0200, 32'h0);
    step();
    bus_err = 1'b1;
    step();
    check("be ack",   32'(rsp_ack), 32'd1);
    check("be err",   32'(rsp_err), 32'd1);
    check("be rdata", rsp_rdata,    32'd0);
    bus_err = 1'b0;
    drive(0, 0, 2'd0, 32'h0, 32'h0);

    // Timeout: silent bus, completion exactly TMO+1 cycles after acceptance.
    drive(1, 0, 2'd0, 32'h0000_0300, 32'h0);
    step();
    for (int i = 1; i <= TMO; i++) begin
      step(); check("to wait", 32'(rsp_ack), 32'd0);
    end
    step();
    check("to ack", 32'(rsp_ack), 32'd1);
    check("to err", 32'(rsp_err), 32'd1);
    drive(1, 0, 2'd0, 32'hFFFF_FFF0, 32'h0);
    step();
    check("post-to ack",   32'(rsp_ack), 32'd1);
    check("post-to err",   32'(rsp_err), 32'd0);
    check("post-to rdata", rsp_rdata,    32'h1111_1111);
    drive(0, 0, 2'd0, 32'h0, 32'h0);

    // Reset in the middle of a bus transaction.
    drive(1, 1, 2'd1, 32'h0000_0400, 32'h5555_5555);
    step(); check("rb cyc", 32'(bus_cyc), 32'd1);
    drive(0, 0, 2'd0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("rb cyc0",  32'(bus_cyc), 32'd0);
    check("rb ack0",  32'(rsp_ack), 32'd0);
    check("rb addr0", bus_addr,     32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step(); check("rb noack", 32'(rsp_ack), 32'd0);
    drive(1, 0, 2'd0, 32'hFFFF_FFF0, 32'h0);
    step(); check("rb rd t0", rsp_rdata, 32'd0);
            check("rb rd ack", 32'(rsp_ack), 32'd1);
    drive(1, 0, 2'd1, 32'hFFFF_FFF1, 32'h0);
    step(); check("rb rd t1", rsp_rdata, 32'd0);
    drive(0, 0, 2'd0, 32'h0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
